// File: rtl/y86_pkg.sv
// Shared Y86-64 encoding constants, loader state type and the icode-to-length table.
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [3:0] RNONE   = 4'hF;

  typedef enum logic {
    ST_READY = 1'b0,
    ST_EMIT  = 1'b1
  } load_state_e;

  // Encoded length in bytes; 0 marks an icode with no encoding.
  function automatic logic [3:0] instr_len(input logic [3:0] icode);
    case (icode)
      IHALT, INOP, IRET:             instr_len = 4'd1;
      IRRMOVQ, IOPQ, IPUSHQ, IPOPQ:  instr_len = 4'd2;
      IJXX, ICALL:                   instr_len = 4'd9;
      IIRMOVQ, IRMMOVQ, IMRMOVQ:     instr_len = 4'd10;
      default:                       instr_len = 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/y86_instr_encoder.sv
// Packs decoded Y86-64 fields into the byte image; byte k lives in byte_buf[8k+7:8k].
module y86_instr_encoder
  import y86_pkg::*;
(
  input  logic [3:0]  icode,
  input  logic [3:0]  ifun,
  input  logic [3:0]  ra,
  input  logic [3:0]  rb,
  input  logic [63:0] val_c,
  output logic [79:0] byte_buf,
  output logic [3:0]  len,
  output logic        valid
);

  always_comb begin
    byte_buf      = '0;
    len           = instr_len(icode);
    valid         = (len != 4'd0);
    byte_buf[7:0] = {icode, ifun};
    case (len)
      4'd2: byte_buf[15:8] = {ra, rb};
      4'd9: byte_buf[71:8] = val_c;
      4'd10: begin
        byte_buf[15:8]  = {ra, rb};
        byte_buf[79:16] = val_c;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/y86_imem_loader.sv
// Writes encoded Y86-64 instructions into byte-wide instruction memory, one byte
// per cycle at a running PC. Handshake: a transfer happens on a rising clk edge where in_valid && in_ready.
module y86_imem_loader
  import y86_pkg::*;
#(
  parameter int MEM_BYTES = 1024,
  parameter int ADDR_W    = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        icode,
  input  logic [3:0]        ifun,
  input  logic [3:0]        rA,
  input  logic [3:0]        rB,
  input  logic [63:0]       valC,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic [ADDR_W-1:0] next_pc,
  output logic              busy,
  output logic              err_invalid,
  output logic              err_bounds,
  output logic [15:0]       instr_count
);

  localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W+1)'(MEM_BYTES);

  load_state_e       state_q, state_d;
  logic [79:0]       buf_q, buf_d;
  logic [3:0]        len_q, len_d;
  logic [3:0]        idx_q, idx_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] next_pc_q, next_pc_d;
  logic [15:0]       count_q, count_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              err_invalid_q, err_invalid_d;
  logic              err_bounds_q, err_bounds_d;

  logic [79:0]       enc_buf;
  logic [3:0]        enc_len;
  logic              enc_valid;
  logic [ADDR_W:0]   end_sum;

  y86_instr_encoder u_encoder (
    .icode    (icode),
    .ifun     (ifun),
    .ra       (rA),
    .rb       (rB),
    .val_c    (valC),
    .byte_buf (enc_buf),
    .len      (enc_len),
    .valid    (enc_valid)
  );

  assign in_ready = (state_q == ST_READY) && !start;
  assign busy     = (state_q == ST_EMIT);

  always_comb begin
    state_d       = state_q;
    buf_d         = buf_q;
    len_d         = len_q;
    idx_d         = idx_q;
    base_d        = base_q;
    next_pc_d     = next_pc_q;
    count_d       = count_q;
    wr_en_d       = 1'b0;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    err_invalid_d = 1'b0;
    err_bounds_d  = 1'b0;
    // One extra bit so a base near the top of the address space cannot wrap past the check.
    end_sum       = {1'b0, next_pc_q} + (ADDR_W+1)'(enc_len);

    case (state_q)
      ST_READY: begin
        if (start) begin
          next_pc_d = base_addr;
        end else if (in_valid) begin
          if (!enc_valid) begin
            err_invalid_d = 1'b1;
          end else if (end_sum > MEM_LIMIT) begin
            err_bounds_d = 1'b1;
          end else begin
            buf_d     = enc_buf;
            len_d     = enc_len;
            base_d    = next_pc_q;
            idx_d     = 4'd1;
            wr_en_d   = 1'b1;
            wr_addr_d = next_pc_q;
            wr_data_d = enc_buf[7:0];
            state_d   = ST_EMIT;
          end
        end
      end
      ST_EMIT: begin
        // idx_q is the index of the byte to present next; reaching len_q means the last byte is on the bus now.
        if (idx_q == len_q) begin
          state_d   = ST_READY;
          next_pc_d = base_q + ADDR_W'(len_q);
          count_d   = count_q + 16'd1;
        end else begin
          wr_en_d   = 1'b1;
          wr_addr_d = base_q + ADDR_W'(idx_q);
          wr_data_d = buf_q[{idx_q, 3'b000} +: 8];
          idx_d     = idx_q + 4'd1;
        end
      end
      default: state_d = ST_READY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_READY;
      buf_q         <= '0;
      len_q         <= '0;
      idx_q         <= '0;
      base_q        <= '0;
      next_pc_q     <= '0;
      count_q       <= '0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      err_invalid_q <= 1'b0;
      err_bounds_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      buf_q         <= buf_d;
      len_q         <= len_d;
      idx_q         <= idx_d;
      base_q        <= base_d;
      next_pc_q     <= next_pc_d;
      count_q       <= count_d;
      wr_en_q       <= wr_en_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      err_invalid_q <= err_invalid_d;
      err_bounds_q  <= err_bounds_d;
    end
  end

  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign next_pc     = next_pc_q;
  assign instr_count = count_q;
  assign err_invalid = err_invalid_q;
  assign err_bounds  = err_bounds_q;

endmodule

// File: tb/tb_y86_imem_loader.sv
// Bench for y86_imem_loader: directed program scenarios plus random instructions
// checked against a byte-level model of the Y86-64 encoding and the loader's PC rules.
module tb_y86_imem_loader;

  localparam int MEM_BYTES = 1024;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start = 1'b0;
  logic [63:0] base_addr = '0;
  logic        in_valid = 1'b0;
  logic [3:0]  icode = '0, ifun = '0, ra = '0, rb = '0;
  logic [63:0] valc = '0;
  logic        in_ready, wr_en, busy, err_invalid, err_bounds;
  logic [63:0] wr_addr, next_pc;
  logic [7:0]  wr_data;
  logic [15:0] instr_count;

  y86_imem_loader #(.MEM_BYTES(MEM_BYTES), .ADDR_W(64)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .base_addr   (base_addr),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .icode       (icode),
    .ifun        (ifun),
    .rA          (ra),
    .rB          (rb),
    .valC        (valc),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .next_pc     (next_pc),
    .busy        (busy),
    .err_invalid (err_invalid),
    .err_bounds  (err_bounds),
    .instr_count (instr_count)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int          total = 0;
  int          bad   = 0;
  logic [71:0] exp_q[$];   // {addr[63:0], data[7:0]}
  logic [63:0] model_pc  = '0;
  logic [15:0] model_cnt = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int ref_len(input logic [3:0] ic);
    case (ic)
      4'h0, 4'h1, 4'h9:       return 1;
      4'h2, 4'h6, 4'hA, 4'hB: return 2;
      4'h7, 4'h8:             return 9;
      4'h3, 4'h4, 4'h5:       return 10;
      default:                return 0;
    endcase
  endfunction

  // Write monitor: every strobe must match the next expected byte, and the
  // write strobe is high exactly while the loader is emitting.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("wr_en_vs_busy", wr_en, busy);
      if (busy) check("ready_in_emit", in_ready, 0);
      if (wr_en) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", wr_addr, 64'hDEAD);
        end else begin
          logic [71:0] e;
          e = exp_q.pop_front();
          check("wr_addr", wr_addr, e[71:8]);
          check("wr_data", {56'd0, wr_data}, {56'd0, e[7:0]});
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_start(input logic [63:0] b);
    @(posedge clk);
    #1;
    start     = 1'b1;
    base_addr = b;
    // A handshake offered alongside start must be refused.
    in_valid  = 1'b1;
    icode     = 4'h1;
    #1 check("ready_during_start", in_ready, 0);
    @(posedge clk);
    #1;
    start    = 1'b0;
    in_valid = 1'b0;
    model_pc = b;
    #1 check("pc_after_start", next_pc, b);
    check("no_write_after_start", wr_en, 0);
  endtask

  task automatic send(input logic [3:0] ic, input logic [3:0] f, input logic [3:0] a,
                      input logic [3:0] b, input logic [63:0] c,
                      input bit mid_start, input bit mid_rst);
    int          len, n, cyc;
    bit          exp_inv, exp_bnd;
    logic [64:0] end_addr;
    logic [63:0] pc0;
    logic [15:0] cnt0;
    icode = ic; ifun = f; ra = a; rb = b; valc = c;
    in_valid = 1'b1;
    #1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("handshake_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    len      = ref_len(ic);
    exp_inv  = (len == 0);
    end_addr = {1'b0, model_pc} + 65'(len);
    exp_bnd  = !exp_inv && (end_addr > 65'(MEM_BYTES));
    pc0      = model_pc;
    cnt0     = model_cnt;
    if (!exp_inv && !exp_bnd) begin
      for (int k = 0; k < len; k++) begin
        logic [7:0] bt;
        int         off;
        off = (len == 10) ? k - 2 : k - 1;
        if (k == 0)                                bt = {ic, f};
        else if ((len == 2 || len == 10) && k == 1) bt = {a, b};
        else                                       bt = c[8*off +: 8];
        exp_q.push_back({model_pc + 64'(k), bt});
      end
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("err_invalid", err_invalid, exp_inv);
    check("err_bounds", err_bounds, exp_bnd);
    check("first_byte_strobe", wr_en, !exp_inv && !exp_bnd);
    if (exp_inv || exp_bnd) begin
      @(negedge clk);
      check("err_pulse_width", {62'd0, err_invalid, err_bounds}, 0);
      check("no_write_on_err", wr_en, 0);
      check("pc_kept_on_err", next_pc, pc0);
      check("count_kept_on_err", instr_count, cnt0);
      return;
    end
    cyc = busy ? 1 : 0;
    while (busy && cyc < 20) begin
      if (mid_start && cyc == 2) begin
        start     = 1'b1;
        base_addr = '0;
      end
      if (mid_rst && cyc == 4) begin
        #1 rst_n = 1'b0;
        exp_q.delete();
        model_pc  = '0;
        model_cnt = '0;
        #1;
        check("rst_wr_en", wr_en, 0);
        check("rst_busy", busy, 0);
        check("rst_next_pc", next_pc, 0);
        check("rst_count", instr_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_rst", in_ready, 1);
        return;
      end
      @(negedge clk);
      start = 1'b0;
      if (busy) cyc++;
    end
    check("emit_cycles", cyc, len);
    model_pc  = model_pc + 64'(len);
    model_cnt = model_cnt + 16'd1;
    check("next_pc", next_pc, model_pc);
    check("instr_count", instr_count, model_cnt);
    check("ready_after_emit", in_ready, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_next_pc", next_pc, 0);
    check("reset_count", instr_count, 0);
    check("reset_ready", in_ready, 1);
    check("reset_busy", busy, 0);
    check("reset_wr_en", wr_en, 0);
    check("reset_wr_addr", wr_addr, 0);
    check("reset_wr_data", {56'd0, wr_data}, 0);
    check("reset_errs", {62'd0, err_invalid, err_bounds}, 0);
    rst_n = 1'b1;

    // irmovq $10, %rax at 420
    do_start(64'd420);
    send(4'h3, 4'h0, 4'hF, 4'h0, 64'd10, 0, 0);
    check("pc_430", next_pc, 64'd430);

    // addq, jmp, halt
    send(4'h6, 4'h0, 4'h2, 4'h3, 64'd0, 0, 0);
    send(4'h7, 4'h0, 4'hF, 4'hF, 64'h1234, 0, 0);
    send(4'h0, 4'h0, 4'h0, 4'h0, 64'd0, 0, 0);
    check("pc_442", next_pc, 64'd442);
    check("count_4", instr_count, 16'd4);

    // invalid icode, then a normal nop
    send(4'hC, 4'h0, 4'h1, 4'h2, 64'd0, 0, 0);
    send(4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 0, 0);

    // bounds at the top of memory
    do_start(64'd1020);
    send(4'h4, 4'h0, 4'h1, 4'h2, 64'h55, 0, 0);
    send(4'hA, 4'h0, 4'h4, 4'hF, 64'd0, 0, 0);
    check("pc_1022", next_pc, 64'd1022);

    // base so high that a 64-bit sum would wrap
    do_start(64'hFFFF_FFFF_FFFF_FFFF);
    send(4'hA, 4'h0, 4'h4, 4'hF, 64'd0, 0, 0);

    // reset during byte 3 of an irmovq
    do_start(64'd100);
    send(4'h3, 4'h0, 4'hF, 4'h1, {$urandom, $urandom}, 0, 1);

    // start during EMIT is ignored
    do_start(64'd200);
    send(4'h5, 4'h0, 4'h3, 4'h4, {$urandom, $urandom}, 1, 0);
    check("pc_210", next_pc, 64'd210);

    // random program fragments
    for (int i = 0; i < 150; i++) begin
      logic [3:0] ic;
      if ($urandom_range(0, 9) == 0)
        do_start($urandom_range(0, 1) ? 64'($urandom_range(0, 1023))
                                       : 64'($urandom_range(1012, 1023)));
      ic = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                       : 4'($urandom_range(0, 11));
      send(ic, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           4'($urandom_range(0, 15)), {$urandom, $urandom}, 0, 0);
    end

    repeat (2) @(negedge clk);
    check("all_bytes_written", 64'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
